// File: rtl/alu_group1_executor_if.sv
// alu_group1_executor_if
// Groups the fetcher handshake and the memory bus of the group-one executor.
//   master : fetcher / memory side (drives instruction and read data)
//   slave  : executor side (drives memory strobes, results, completion)
// Signals:
//   instruction_ready  fetcher has a complete instruction (held until done)
//   instruction_in     opcode
//   addr_in            effective operand address
//   imm_in             immediate operand
//   mem_data_in        read data, valid the cycle after mem_re
//   mem_addr           memory address
//   mem_data_out       write data
//   mem_re / mem_we    one-cycle read / write strobes
//   acc_out            accumulator
//   status_out         N V 1 B D I Z C (bit7..0)
//   instruction_done   one-cycle completion pulse
//   illegal            one-cycle pulse with instruction_done for bad opcodes
interface alu_group1_executor_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  instruction_ready;
    logic [REG_WIDTH-1:0]  instruction_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [REG_WIDTH-1:0]  imm_in;
    logic [REG_WIDTH-1:0]  mem_data_in;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_data_out;
    logic                  mem_re;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  acc_out;
    logic [REG_WIDTH-1:0]  status_out;
    logic                  instruction_done;
    logic                  illegal;

    modport master (
        output instruction_ready, instruction_in, addr_in, imm_in, mem_data_in,
        input  mem_addr, mem_data_out, mem_re, mem_we, acc_out, status_out,
               instruction_done, illegal
    );

    modport slave (
        input  instruction_ready, instruction_in, addr_in, imm_in, mem_data_in,
        output mem_addr, mem_data_out, mem_re, mem_we, acc_out, status_out,
               instruction_done, illegal
    );
endinterface

// File: rtl/alu_group1_executor.sv
// alu_group1_executor
// Execute stage for the 6502 group-one instructions (opcode[1:0] = 01):
// ORA, AND, EOR, ADC, STA, LDA, CMP, SBC, binary mode only. Owns the
// accumulator and the status register and pulses instruction_done once
// each accepted instruction has completed.
// Ports:
//   phi1   clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   bus    alu_group1_executor_if.slave (fetcher handshake + memory bus)
module alu_group1_executor #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  phi1,
    input  logic                  reset,
    alu_group1_executor_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_DATA,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ORA = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_ADC = 3'd3;
    localparam logic [2:0] OP_STA = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_SBC = 3'd7;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [2:0]            aaa_q, aaa_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  operand_q, operand_d;
    logic                  illegal_q, illegal_d;
    logic [REG_WIDTH-1:0]  acc_q, acc_d;
    logic                  n_q, n_d;
    logic                  v_q, v_d;
    logic                  z_q, z_d;
    logic                  c_q, c_d;

    // Decode of the incoming opcode, used only on the accept edge.
    logic [2:0] in_aaa;
    logic [2:0] in_bbb;
    logic       in_illegal;
    logic       accept;

    assign in_aaa     = bus.instruction_in[7:5];
    assign in_bbb     = bus.instruction_in[4:2];
    // 0x89 would be "STA immediate", which has no meaning.
    assign in_illegal = (bus.instruction_in[1:0] != 2'b01) ||
                        (bus.instruction_in[7:0] == 8'h89);
    // Launch only on a low-to-high transition of instruction_ready.
    assign accept     = bus.instruction_ready && !ready_q;

    // Shared adder: SBC and CMP add the inverted operand. CMP forces the
    // carry-in to 1 so the carry-out equals (A >= M).
    logic [REG_WIDTH-1:0] m_eff;
    logic                 carry_in;
    logic [REG_WIDTH:0]   sum;
    logic [REG_WIDTH-1:0] ovf_vec;

    always_comb begin
        m_eff    = ((aaa_q == OP_SBC) || (aaa_q == OP_CMP)) ? ~operand_q : operand_q;
        carry_in = (aaa_q == OP_CMP) ? 1'b1 : c_q;
        sum      = {1'b0, acc_q} + {1'b0, m_eff} + {{REG_WIDTH{1'b0}}, carry_in};
        // Signed overflow: operands agree in sign, result disagrees.
        ovf_vec  = ~(acc_q ^ m_eff) & (acc_q ^ sum[REG_WIDTH-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = bus.instruction_ready;
        aaa_d     = aaa_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        n_d       = n_q;
        v_d       = v_q;
        z_d       = z_q;
        c_d       = c_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    aaa_d     = in_aaa;
                    addr_d    = bus.addr_in;
                    operand_d = bus.imm_in;
                    illegal_d = in_illegal;
                    if (in_illegal)
                        state_d = S_DONE;
                    else if (in_aaa == OP_STA)
                        state_d = S_WRITE;
                    else if (in_bbb == 3'b010)
                        state_d = S_EXEC;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                operand_d = bus.mem_data_in;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                case (aaa_q)
                    OP_ORA, OP_AND, OP_EOR, OP_LDA: begin
                        case (aaa_q)
                            OP_ORA:  acc_d = acc_q | operand_q;
                            OP_AND:  acc_d = acc_q & operand_q;
                            OP_EOR:  acc_d = acc_q ^ operand_q;
                            default: acc_d = operand_q;
                        endcase
                        n_d = acc_d[REG_WIDTH-1];
                        z_d = (acc_d == '0);
                    end
                    OP_ADC, OP_SBC: begin
                        acc_d = sum[REG_WIDTH-1:0];
                        c_d   = sum[REG_WIDTH];
                        v_d   = ovf_vec[REG_WIDTH-1];
                        n_d   = sum[REG_WIDTH-1];
                        z_d   = (sum[REG_WIDTH-1:0] == '0);
                    end
                    OP_CMP: begin
                        c_d = sum[REG_WIDTH];
                        n_d = sum[REG_WIDTH-1];
                        z_d = (sum[REG_WIDTH-1:0] == '0);
                    end
                    default: ;
                endcase
                state_d = S_DONE;
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            // Treat instruction_ready as already high so a request held
            // across reset is not launched.
            ready_q   <= 1'b1;
            aaa_q     <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            aaa_q     <= aaa_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            v_q       <= v_d;
            z_q       <= z_d;
            c_q       <= c_d;
        end
    end

    // Outputs are decoded straight from the state register so they drop
    // together with the asynchronous reset.
    logic [REG_WIDTH-1:0] status_vec;

    always_comb begin
        status_vec    = '0;
        status_vec[7] = n_q;
        status_vec[6] = v_q;
        status_vec[5] = 1'b1;
        status_vec[1] = z_q;
        status_vec[0] = c_q;
    end

    assign bus.mem_re           = (state_q == S_READ);
    assign bus.mem_we           = (state_q == S_WRITE);
    assign bus.mem_addr         = ((state_q == S_READ) || (state_q == S_WRITE)) ? addr_q : '0;
    assign bus.mem_data_out     = (state_q == S_WRITE) ? acc_q : '0;
    assign bus.acc_out          = acc_q;
    assign bus.status_out       = status_vec;
    assign bus.instruction_done = (state_q == S_DONE);
    assign bus.illegal          = (state_q == S_DONE) && illegal_q;

endmodule

// File: tb/tb_alu_group1_executor.sv
// Testbench for alu_group1_executor: directed cases from the test plan,
// reset scenarios and randomized instructions, checked by a scoreboard.
module tb_alu_group1_executor;

    localparam int RW = 8;
    localparam int AW = 16;

    logic phi1  = 1'b0;
    logic reset = 1'b1;

    alu_group1_executor_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    alu_group1_executor #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .phi1  (phi1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        logic [7:0]  acc;
        logic [7:0]  status;
        logic [7:0]  wdata;
        int          ill;
        int          lat;
        int          nre;
        int          nwe;
        int          t0;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:65535];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    // Reference architectural state.
    int m_acc = 0, m_n = 0, m_v = 0, m_z = 0, m_c = 0;

    always @(posedge phi1) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int to_signed8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic logic [7:0] model_status();
        return {m_n[0], m_v[0], 1'b1, 3'b000, m_z[0], m_c[0]};
    endfunction

    // Memory: data for a read strobe is presented only during the
    // following cycle; other cycles carry garbage.
    bit          pend = 0;
    logic [15:0] paddr;
    always @(negedge phi1) begin
        if (!reset && bus.mem_re) begin
            pend  = 1;
            paddr = bus.mem_addr;
        end
    end
    always @(posedge phi1) begin
        #1;
        if (pend) begin
            bus.mem_data_in = mem[paddr];
            pend = 0;
        end else begin
            bus.mem_data_in = 8'($urandom);
        end
    end

    // Monitor / scoreboard.
    int re_cnt = 0;
    int we_cnt = 0;
    always @(negedge phi1) begin
        exp_t e;
        if (reset) begin
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            if (bus.mem_re) begin
                re_cnt++;
                if (sb.size() > 0) chk("re_addr", int'(bus.mem_addr), int'(sb[0].addr));
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (sb.size() > 0) begin
                    chk("we_addr", int'(bus.mem_addr), int'(sb[0].addr));
                    chk("we_data", int'(bus.mem_data_out), int'(sb[0].wdata));
                end
            end
            if (bus.illegal) chk("illegal_with_done", int'(bus.instruction_done), 1);
            if (bus.instruction_done) begin
                if (sb.size() == 0) begin
                    chk("done_with_empty_queue", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    $display("op=%02h addr=%04h lat=%0d acc=%02h status=%02h illegal=%0d",
                             e.op, e.addr, cyc - e.t0, bus.acc_out, bus.status_out, bus.illegal);
                    chk("latency", cyc - e.t0, e.lat);
                    chk("acc", int'(bus.acc_out), int'(e.acc));
                    chk("status", int'(bus.status_out), int'(e.status));
                    chk("illegal", int'(bus.illegal), e.ill);
                    chk("re_count", re_cnt, e.nre);
                    chk("we_count", we_cnt, e.nwe);
                end
                re_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    task automatic model_reset();
        m_acc = 0; m_n = 0; m_v = 0; m_z = 0; m_c = 0;
    endtask

    // Computes the expected outcome from the instruction semantics, pushes
    // it, then drives the handshake until the done pulse.
    task automatic issue(input logic [7:0] op, input logic [15:0] addr,
                         input logic [7:0] imm, input int hold);
        exp_t e;
        int   aaa, bbb, m, s, ss, r;
        bit   got;
        aaa     = int'(op[7:5]);
        bbb     = int'(op[4:2]);
        e.op    = op;
        e.addr  = addr;
        e.nre   = 0;
        e.nwe   = 0;
        e.wdata = 8'h00;
        e.ill   = ((op[1:0] != 2'b01) || (op == 8'h89)) ? 1 : 0;
        if (e.ill == 1) begin
            e.lat = 1;
        end else if (aaa == 4) begin
            e.lat     = 2;
            e.nwe     = 1;
            e.wdata   = 8'(m_acc);
            mem[addr] = 8'(m_acc);
        end else begin
            if (bbb == 2) begin
                m     = int'(imm);
                e.lat = 2;
            end else begin
                m     = int'(mem[addr]);
                e.lat = 4;
                e.nre = 1;
            end
            r = 0;
            case (aaa)
                0: begin m_acc = m_acc | m; r = m_acc; end
                1: begin m_acc = m_acc & m; r = m_acc; end
                2: begin m_acc = m_acc ^ m; r = m_acc; end
                5: begin m_acc = m;         r = m_acc; end
                3: begin
                    s     = m_acc + m + m_c;
                    ss    = to_signed8(m_acc) + to_signed8(m) + m_c;
                    m_c   = (s > 255) ? 1 : 0;
                    m_v   = (ss > 127 || ss < -128) ? 1 : 0;
                    m_acc = s % 256;
                    r     = m_acc;
                end
                7: begin
                    s     = m_acc - m - (1 - m_c);
                    ss    = to_signed8(m_acc) - to_signed8(m) - (1 - m_c);
                    m_c   = (s >= 0) ? 1 : 0;
                    m_v   = (ss > 127 || ss < -128) ? 1 : 0;
                    m_acc = (s + 256) % 256;
                    r     = m_acc;
                end
                default: begin
                    m_c = (m_acc >= m) ? 1 : 0;
                    r   = (m_acc - m + 256) % 256;
                end
            endcase
            m_n = (r >= 128) ? 1 : 0;
            m_z = (r == 0) ? 1 : 0;
        end
        e.acc    = 8'(m_acc);
        e.status = model_status();

        @(negedge phi1);
        bus.instruction_in    = op;
        bus.addr_in           = addr;
        bus.imm_in            = imm;
        bus.instruction_ready = 1'b1;
        e.t0                  = cyc;
        sb.push_back(e);
        @(posedge phi1);
        #1;
        // Only the latched copies may matter from here on.
        bus.instruction_in = 8'($urandom);
        bus.addr_in        = 16'($urandom);
        bus.imm_in         = 8'($urandom);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge phi1);
            if (bus.instruction_done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", int'(got), 1);
        repeat (hold) @(negedge phi1);
        bus.instruction_ready = 1'b0;
        @(negedge phi1);
    endtask

    task automatic check_regs(input string name, input logic [7:0] acc, input logic [7:0] st);
        chk({name, "_acc"}, int'(bus.acc_out), int'(acc));
        chk({name, "_status"}, int'(bus.status_out), int'(st));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_acc"}, int'(bus.acc_out), 0);
        chk({name, "_status"}, int'(bus.status_out), 32'h20);
        chk({name, "_mem_re"}, int'(bus.mem_re), 0);
        chk({name, "_mem_we"}, int'(bus.mem_we), 0);
        chk({name, "_mem_addr"}, int'(bus.mem_addr), 0);
        chk({name, "_done"}, int'(bus.instruction_done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] addr;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0042] = 8'h00;

        // Stale instruction_ready held through reset must not launch.
        bus.instruction_ready = 1'b1;
        bus.instruction_in    = 8'hA9;
        bus.addr_in           = 16'h0000;
        bus.imm_in            = 8'h77;
        bus.mem_data_in       = 8'h00;
        repeat (3) @(negedge phi1);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge phi1);
            chk("stale_ready_no_launch", int'(bus.acc_out), 0);
        end
        bus.instruction_ready = 1'b0;
        @(negedge phi1);

        // Directed cases from the test plan.
        issue(8'hA9, 16'h0000, 8'h80, 0); check_regs("lda_imm80", 8'h80, 8'hA0);
        issue(8'hA9, 16'h0000, 8'h50, 1);
        issue(8'h69, 16'h0000, 8'h50, 0); check_regs("adc_50", 8'hA0, 8'hE0);
        issue(8'h69, 16'h0000, 8'h60, 2); check_regs("adc_60", 8'h00, 8'h23);
        issue(8'hA5, 16'h0042, 8'hFF, 0); check_regs("lda_zpg", 8'h00, 8'h23);
        issue(8'hA9, 16'h0000, 8'h5A, 0);
        issue(8'h8D, 16'h1234, 8'h00, 0); check_regs("sta_abs", 8'h5A, 8'h21);
        issue(8'hA9, 16'h0000, 8'h10, 0);
        issue(8'hC9, 16'h0000, 8'h10, 0); check_regs("cmp_10", 8'h10, 8'h23);
        issue(8'hA9, 16'h0000, 8'h00, 0);
        issue(8'hE9, 16'h0000, 8'h01, 0); check_regs("sbc_01", 8'hFF, 8'hA0);
        issue(8'h89, 16'h2000, 8'h00, 0); check_regs("illegal_89", 8'hFF, 8'hA0);
        issue(8'hEA, 16'h2000, 8'h00, 1); check_regs("illegal_ea", 8'hFF, 8'hA0);

        // Reset during WAIT_DATA, with instruction_ready held high.
        @(negedge phi1);
        bus.instruction_in    = 8'hA5;
        bus.addr_in           = 16'h0042;
        bus.instruction_ready = 1'b1;
        @(posedge phi1);
        @(posedge phi1);
        @(negedge phi1);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("reset_wait_data");
        @(negedge phi1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge phi1);
            chk("no_launch_after_reset_re", int'(bus.mem_re), 0);
        end
        bus.instruction_ready = 1'b0;
        @(negedge phi1);

        // Reset while a write strobe is in flight.
        issue(8'hA9, 16'h0000, 8'h3C, 0);
        @(negedge phi1);
        bus.instruction_in    = 8'h8D;
        bus.addr_in           = 16'hBEEF;
        bus.instruction_ready = 1'b1;
        @(negedge phi1);
        chk("we_before_reset", int'(bus.mem_we), 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("reset_write");
        @(negedge phi1);
        reset = 1'b0;
        bus.instruction_ready = 1'b0;
        repeat (2) @(negedge phi1);

        // Randomized instructions.
        for (int n = 0; n < 300; n++) begin
            op = 8'($urandom);
            if ($urandom_range(0, 99) < 85) op[1:0] = 2'b01;
            addr = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            issue(op, addr, 8'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge phi1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
